// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage. Holds the program counter, fetches one instruction
// word per step from instruction memory over a req/ack handshake, and presents
// the instruction register for exactly one execute cycle. After that cycle
// the PC advances by one or jumps to the low PC_W bits of the instruction.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   run         in   1 = keep fetching; 0 = park in IDLE after current instr
//   s_inc       in   sampled in EXEC: 1 = pc+1, 0 = jump to IR[PC_W-1:0]
//   imem_rdata  in   instruction word from memory
//   imem_ack    in   memory data valid (honoured only while requesting)
//   imem_req    out  fetch request, registered, high only in REQ
//   imem_addr   out  fetch address, always equal to pc
//   instr       out  instruction register
//   opcode      out  IR[INSTR_W-1 -: 6]
//   exec_en     out  one-cycle execute strobe, registered
//   pc          out  program counter
//   fetch_err   out  sticky memory timeout fault
//
// INSTR_W must be at least 6 + PC_W so the opcode and jump target fit.
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter int PC_W        = 10,
  parameter int INSTR_W     = 16,
  parameter int RESET_PC    = 0,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               s_inc,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         opcode,
  output logic               exec_en,
  output logic [PC_W-1:0]    pc,
  output logic               fetch_err
);

  // Counter wide enough to reach TIMEOUT_CYC; one bit when the timeout is off.
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYC > 0);
  localparam logic [CNT_W:0]   TO_VAL  = (CNT_W + 1)'(TIMEOUT_CYC);
  localparam logic [PC_W-1:0]  PC_RST  = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
  localparam logic [CNT_W:0]   CNT_ONE = (CNT_W + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_EXEC = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               req_q, exec_q;
  logic [CNT_W:0]     cnt_inc;

  // Extra top bit keeps the wait count from wrapping before the compare.
  assign cnt_inc = {1'b0, cnt_q} + CNT_ONE;

  // Next-state, PC, IR, timeout counter and fault computation.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_REQ;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        // Ack takes priority over a timeout on the same edge.
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ST_EXEC;
        end else if (TO_EN && (cnt_inc == TO_VAL)) begin
          state_d = ST_HALT;
          err_d   = 1'b1;
        end else begin
          cnt_d = TO_EN ? cnt_inc[CNT_W-1:0] : '0;
        end
      end
      ST_EXEC: begin
        if (s_inc) begin
          pc_d = pc_q + PC_ONE;
        end else begin
          pc_d = ir_q[PC_W-1:0];
        end
        cnt_d = '0;
        if (run) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath registers and registered strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= PC_RST;
      ir_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      exec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      // Strobes decoded from the next state so they are glitch-free flops.
      req_q   <= (state_d == ST_REQ);
      exec_q  <= (state_d == ST_EXEC);
    end
  end

  assign imem_req  = req_q;
  assign exec_en   = exec_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = ir_q;
  assign opcode    = ir_q[INSTR_W-1 -: 6];
  assign fetch_err = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        run2 = 1'b0;
  logic        s_inc = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        imem_ack = 1'b0;

  logic        imem_req, exec_en, fetch_err;
  logic [9:0]  imem_addr, pc;
  logic [15:0] instr;
  logic [5:0]  opcode;

  logic        imem_req2, exec_en2, fetch_err2;
  logic [9:0]  imem_addr2, pc2;
  logic [15:0] instr2;
  logic [5:0]  opcode2;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: what the stage is doing, tracked as plain booleans.
  bit          m_fetching, m_executing, m_halted, m_err;
  int          m_waits;
  int          m_pc;
  logic [15:0] m_ir;

  instr_fetch u_dut (
    .clk(clk), .reset(reset), .run(run), .s_inc(s_inc),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .imem_req(imem_req), .imem_addr(imem_addr), .instr(instr),
    .opcode(opcode), .exec_en(exec_en), .pc(pc), .fetch_err(fetch_err)
  );

  instr_fetch #(.RESET_PC(32'h20), .TIMEOUT_CYC(0)) u_dut2 (
    .clk(clk), .reset(reset), .run(run2), .s_inc(s_inc),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .instr(instr2),
    .opcode(opcode2), .exec_en(exec_en2), .pc(pc2), .fetch_err(fetch_err2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fetching = 1'b0; m_executing = 1'b0; m_halted = 1'b0; m_err = 1'b0;
    m_waits = 0; m_pc = 0; m_ir = 16'h0000;
  endtask

  // One clock edge worth of behaviour, from the inputs in force at the edge.
  task automatic model_step();
    if (m_halted) begin
      // frozen until reset
    end else if (m_executing) begin
      m_pc = s_inc ? (m_pc + 1) % 1024 : int'(m_ir) % 1024;
      m_executing = 1'b0;
      m_fetching = run;
      m_waits = 0;
    end else if (m_fetching) begin
      if (imem_ack) begin
        m_ir = imem_rdata;
        m_fetching = 1'b0;
        m_executing = 1'b1;
      end else begin
        m_waits++;
        if (m_waits == TO) begin
          m_fetching = 1'b0;
          m_halted = 1'b1;
          m_err = 1'b1;
        end
      end
    end else if (run) begin
      m_fetching = 1'b1;
      m_waits = 0;
    end
  endtask

  task automatic model_cmp();
    chk("imem_req",  {31'd0, imem_req},  {31'd0, m_fetching});
    chk("exec_en",   {31'd0, exec_en},   {31'd0, m_executing});
    chk("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
    chk("pc",        {22'd0, pc},        32'(m_pc));
    chk("imem_addr", {22'd0, imem_addr}, 32'(m_pc));
    chk("instr",     {16'd0, instr},     {16'd0, m_ir});
    chk("opcode",    {26'd0, opcode},    {26'd0, m_ir[15:10]});
  endtask

  // Drive inputs at the falling edge, advance model on the rising edge,
  // compare at the next falling edge.
  task automatic step(input logic r, input logic s, input logic a, input logic [15:0] d);
    run = r; s_inc = s; imem_ack = a; imem_rdata = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_cmp();
  endtask

  initial begin
    int req_cycles;
    logic [9:0] pc_frozen;

    // ---- reset values ----
    @(negedge clk);
    @(negedge clk);
    model_reset();
    model_cmp();
    chk("rst_pc", {22'd0, pc}, 32'h0);
    chk("rst_instr", {16'd0, instr}, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'h0);
    chk("rst_pc2", {22'd0, pc2}, 32'h20);
    chk("rst_addr2", {22'd0, imem_addr2}, 32'h20);
    reset = 1'b0;

    // ---- zero-wait fetch, s_inc=1 ----
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("first_req", {31'd0, imem_req}, 32'h1);
    chk("first_addr", {22'd0, imem_addr}, 32'h0);
    step(1'b1, 1'b1, 1'b1, 16'h0123);
    chk("alu_exec", {31'd0, exec_en}, 32'h1);
    chk("alu_opcode", {26'd0, opcode}, 32'h00);
    chk("alu_instr", {16'd0, instr}, 32'h0123);
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("inc_pc", {22'd0, pc}, 32'h1);
    chk("inc_addr", {22'd0, imem_addr}, 32'h1);
    chk("inc_req", {31'd0, imem_req}, 32'h1);
    chk("inc_exec_off", {31'd0, exec_en}, 32'h0);

    // ---- jump ----
    step(1'b1, 1'b0, 1'b1, 16'hF005);
    chk("jmp_opcode", {26'd0, opcode}, 32'h3C);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("jmp_pc", {22'd0, pc}, 32'h5);
    chk("jmp_addr", {22'd0, imem_addr}, 32'h5);

    // ---- wrap at top of PC space ----
    step(1'b1, 1'b0, 1'b1, 16'h03FF);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("top_pc", {22'd0, pc}, 32'h3FF);
    step(1'b1, 1'b1, 1'b1, 16'h1234);
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("wrap_pc", {22'd0, pc}, 32'h0);

    // ---- three wait states ----
    req_cycles = int'(imem_req);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'($urandom));
      req_cycles += int'(imem_req);
      chk("wait_ir_hold", {16'd0, instr}, 32'h1234);
    end
    step(1'b1, 1'b1, 1'b1, 16'hABCD);
    chk("wait_req_cycles", 32'(req_cycles), 32'd4);
    chk("wait_ir", {16'd0, instr}, 32'hABCD);
    // spurious acks in EXEC and IDLE
    step(1'b0, 1'b1, 1'b1, 16'h5555);
    chk("spur_exec_ir", {16'd0, instr}, 32'hABCD);
    step(1'b0, 1'b1, 1'b1, 16'h6666);
    chk("spur_idle_ir", {16'd0, instr}, 32'hABCD);
    chk("idle_req", {31'd0, imem_req}, 32'h0);

    // ---- run dropped during REQ ----
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    chk("run0_still_req", {31'd0, imem_req}, 32'h1);
    step(1'b0, 1'b1, 1'b1, 16'h0777);
    chk("run0_exec", {31'd0, exec_en}, 32'h1);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    chk("run0_idle_req", {31'd0, imem_req}, 32'h0);
    chk("run0_idle_exec", {31'd0, exec_en}, 32'h0);

    // ---- ack on the 15th REQ cycle beats timeout ----
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < TO - 1; i++) step(1'b1, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 16'h0BEE);
    chk("late_ack_exec", {31'd0, exec_en}, 32'h1);
    chk("late_ack_err", {31'd0, fetch_err}, 32'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0000);

    // ---- randomized traffic ----
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 16'($urandom));
    end

    // ---- async reset mid-REQ ----
    for (int i = 0; i < 4; i++) begin
      if (m_fetching) break;
      step(1'b1, 1'b0, 1'b0, 16'h0000);
    end
    chk("pre_reset_req", {31'd0, imem_req}, 32'h1);
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_req", {31'd0, imem_req}, 32'h0);
    chk("async_pc", {22'd0, pc}, 32'h0);
    chk("async_instr", {16'd0, instr}, 32'h0);
    model_cmp();
    @(negedge clk);
    reset = 1'b0;

    // ---- timeout to HALT; second instance has timeout disabled ----
    run2 = 1'b1;
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < TO - 1; i++) step(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("to_pre_req", {31'd0, imem_req}, 32'h1);
    chk("to_pre_err", {31'd0, fetch_err}, 32'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("to_req", {31'd0, imem_req}, 32'h0);
    chk("to_err", {31'd0, fetch_err}, 32'h1);
    chk("noto_req2", {31'd0, imem_req2}, 32'h1);
    chk("noto_err2", {31'd0, fetch_err2}, 32'h0);
    pc_frozen = pc;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 16'($urandom));
    chk("halt_pc", {22'd0, pc}, {22'd0, pc_frozen});
    chk("halt_err", {31'd0, fetch_err}, 32'h1);
    chk("halt_exec", {31'd0, exec_en}, 32'h0);

    // ---- reset clears the fault ----
    run2 = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    model_cmp();
    chk("final_err", {31'd0, fetch_err}, 32'h0);
    chk("final_pc2", {22'd0, pc2}, 32'h20);
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
